// File: rtl/ext_bus_pkg.sv
// Shared types and timing constants for the parallel host bus initiator.
// EXT_BUS_WORD32_EN selects 32-bit request data (two halfword accesses per request).
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        TURN
    } bus_state_e;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 6;
    localparam int DEF_HOLD_CYCLES   = 1;
    localparam int DEF_TURN_CYCLES   = 2;

    // Longest phase the shared counter can time; counter holds N-1.
    localparam int MAX_PHASE_CYCLES = 64;
    localparam int CNT_W            = $clog2(MAX_PHASE_CYCLES);

`ifdef EXT_BUS_WORD32_EN
    localparam int DW = 32;
`else
    localparam int DW = 16;
`endif

    // Counter load value for a phase lasting 'cycles' clocks.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ext_bus_phase_cnt.sv
// Loadable down-counter shared by all bus phases; zero_o marks the last cycle of a phase.
module ext_bus_phase_cnt
    import ext_bus_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load on phase entry, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ext_bus_initiator.sv
// Valid/ready request port driving the 16-bit asynchronous parallel host bus.
// EXT_BUS_WORD32_EN: 32-bit requests, each split into low then high halfword accesses.
module ext_bus_initiator
    import ext_bus_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int TURN_CYCLES   = DEF_TURN_CYCLES
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_write_i,
    input  logic [24:0]   req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic [24:0]   addr_o,
    output logic [15:0]   data_o,
    input  logic [15:0]   data_i,
    output logic          data_oe_o,
    output logic          read_o,
    output logic          write_o,
    output logic [1:0]    cs_o
);

    localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TURN_LD   = phase_load(TURN_CYCLES);

    bus_state_e       state_q, state_d;
    logic             write_q;
    logic [24:0]      addr_q;
    logic [DW-1:0]    wdata_q;
    logic             cur_write;
    logic [24:0]      cur_addr;
    logic [DW-1:0]    cur_wdata;
    logic             last_half;
    logic [24:0]      bus_addr_d;
    logic [15:0]      bus_wdata_d;
    logic [DW-1:0]    rdata_next;
    logic             strobe_end;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic [1:0]       cs_q;
    logic             read_n_q, write_n_q, data_oe_q, rsp_valid_q;
    logic [24:0]      bus_addr_q;
    logic [15:0]      bus_data_q;
    logic [DW-1:0]    rdata_q;

    assign strobe_end = (state_q == STROBE) && (state_d == HOLD);

    // Request fields in effect: live inputs on the accept cycle, latched copy afterwards
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_write = req_write_i;
            cur_addr  = req_addr_i;
            cur_wdata = req_wdata_i;
        end
    end

`ifdef EXT_BUS_WORD32_EN
    logic        half_q, half_d;
    logic [15:0] rdata_lo_q;

    // Halfword selector: low half on accept, high half once the low half has finished
    always_comb begin
        half_d = half_q;
        if (state_q == IDLE) begin
            half_d = 1'b0;
        end else if (state_d == SETUP && state_q != SETUP) begin
            half_d = 1'b1;
        end
    end

    // Halfword tracker and buffer for the low half of a read
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            half_q     <= 1'b0;
            rdata_lo_q <= '0;
        end else begin
            half_q <= half_d;
            if (strobe_end && !write_q && !half_q) begin
                rdata_lo_q <= data_i;
            end
        end
    end

    assign last_half   = half_q;
    assign bus_addr_d  = (cur_addr & ~25'd1) + {23'd0, half_d, 1'b0};
    assign bus_wdata_d = half_d ? cur_wdata[31:16] : cur_wdata[15:0];
    assign rdata_next  = {data_i, rdata_lo_q};
`else
    assign last_half   = 1'b1;
    assign bus_addr_d  = cur_addr;
    assign bus_wdata_d = cur_wdata;
    assign rdata_next  = data_i;
`endif

    // Phase sequencing; each timed phase exits on the last counter cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = SETUP;
            SETUP:   if (cnt_zero) state_d = STROBE;
            STROBE:  if (cnt_zero) state_d = HOLD;
            HOLD:    if (cnt_zero) state_d = !write_q ? TURN : (last_half ? IDLE : SETUP);
            TURN:    if (cnt_zero) state_d = last_half ? IDLE : SETUP;
            default: state_d = IDLE;
        endcase
    end

    // Reload the shared counter with the length of whichever phase is entered next
    always_comb begin
        cnt_load = (state_d != state_q);
        case (state_d)
            SETUP:   cnt_val = SETUP_LD;
            STROBE:  cnt_val = STROBE_LD;
            HOLD:    cnt_val = HOLD_LD;
            TURN:    cnt_val = TURN_LD;
            default: cnt_val = '0;
        endcase
    end

    ext_bus_phase_cnt u_phase_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // FSM state, request latches and registered pad controls decoded from the next state
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 2'b00;
            read_n_q    <= 1'b1;
            write_n_q   <= 1'b1;
            data_oe_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= strobe_end && last_half;
            if (state_q == IDLE && req_valid_i) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            case (state_d)
                SETUP: begin
                    cs_q       <= 2'b00;
                    bus_addr_q <= bus_addr_d;
                    read_n_q   <= cur_write;
                    write_n_q  <= ~cur_write;
                    data_oe_q  <= cur_write;
                    if (cur_write) begin
                        bus_data_q <= bus_wdata_d;
                    end
                end
                STROBE: cs_q <= 2'b11;
                HOLD: begin
                    cs_q      <= 2'b00;
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                end
                default: begin
                    cs_q      <= 2'b00;
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                    data_oe_q <= 1'b0;
                end
            endcase
        end
    end

    // Read data captured once, on the edge that ends STROBE of the final halfword
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rdata_q <= '0;
        end else if (strobe_end && !write_q && last_half) begin
            rdata_q <= rdata_next;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign addr_o      = bus_addr_q;
    assign data_o      = bus_data_q;
    assign data_oe_o   = data_oe_q;
    assign read_o      = read_n_q;
    assign write_o     = write_n_q;
    assign cs_o        = cs_q;

endmodule
